// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and default bit period, common to serial TX and RX.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 10417;
    localparam int CNT_W                = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit; 2-cycle latency, reset value set by RST_VAL.
// No flow control: the output follows the input two clocks later.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, mid-bit sampling; byte valid ~2 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + 2 clocks after start edge.
// No backpressure: o_data_valid / o_frame_err are single-cycle pulses the consumer must capture.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    output logic       o_data_valid,
    output logic [7:0] o_data_byte,
    output logic       o_frame_err,
    output logic       o_active
);

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_s;
    rx_state_t        state;
    logic [CNT_W-1:0] counter;
    logic [2:0]       index;
    logic [7:0]       shift;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (i_rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            counter      <= '0;
            index        <= '0;
            shift        <= '0;
            o_data_byte  <= '0;
            o_data_valid <= 1'b0;
            o_frame_err  <= 1'b0;
            o_active     <= 1'b0;
        end else begin
            o_data_valid <= 1'b0;
            o_frame_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    counter <= '0;
                    index   <= '0;
                    if (!rx_s) begin
                        state    <= S_START;
                        o_active <= 1'b1;
                    end
                end
                // Re-check the start bit at its centre so short glitches are rejected.
                S_START: begin
                    if (counter == HALF_CNT) begin
                        counter <= '0;
                        if (!rx_s) begin
                            state <= S_DATA;
                        end else begin
                            state    <= S_IDLE;
                            o_active <= 1'b0;
                        end
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                S_DATA: begin
                    if (counter == LAST_CNT) begin
                        counter      <= '0;
                        shift[index] <= rx_s;
                        if (index == 3'd7) begin
                            index <= '0;
                            state <= S_STOP;
                        end else begin
                            index <= index + 1'b1;
                        end
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                S_STOP: begin
                    if (counter == LAST_CNT) begin
                        counter <= '0;
                        if (rx_s) begin
                            o_data_byte  <= shift;
                            o_data_valid <= 1'b1;
                            o_active     <= 1'b0;
                            state        <= S_IDLE;
                        end else begin
                            o_frame_err <= 1'b1;
                            state       <= S_BREAK;
                        end
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                // Wait out a stuck-low line before hunting for the next start bit.
                S_BREAK: begin
                    counter <= '0;
                    if (rx_s) begin
                        state    <= S_IDLE;
                        o_active <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    counter  <= '0;
                    index    <= '0;
                    o_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a serializer task pushes expected bytes / frame errors,
// a negedge monitor pops and compares them, including the start-edge-to-pulse latency.
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = (CPB - 1) / 2;
    localparam int LAT  = 2 + HALF + 9 * CPB + 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_rx  = 1'b1;
    logic       o_data_valid;
    logic [7:0] o_data_byte;
    logic       o_frame_err;
    logic       o_active;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         t0;
    } evt_t;

    evt_t       exp_q[$];
    evt_t       mon_e;
    int         compared   = 0;
    int         mismatched = 0;
    int         cyc        = 0;
    int         lat;
    logic [7:0] model_byte = 8'h00;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_rx         (i_rx),
        .o_data_valid (o_data_valid),
        .o_data_byte  (o_data_byte),
        .o_frame_err  (o_frame_err),
        .o_active     (o_active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Ideal serializer: start bit, 8 data bits LSB first, one stop bit, CPB cycles each.
    task automatic send_frame(input logic [7:0] b, input logic stop_b, input bit track);
        evt_t e;
        @(negedge clk);
        if (track) begin
            e.is_err = !stop_b;
            e.data   = b;
            e.t0     = cyc;
            exp_q.push_back(e);
        end
        i_rx = 1'b0;
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            i_rx = b[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk);
        i_rx = stop_b;
        repeat (CPB - 1) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_data_valid && o_frame_err) begin
                compared++;
                mismatched++;
                $display("FAIL pulse exclusivity: valid and frame_err both high at cycle %0d", cyc);
            end
            if (o_data_valid || o_frame_err) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected pulse: valid=%0b frame_err=%0b byte=0x%0h, expected none",
                             o_data_valid, o_frame_err, o_data_byte);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("event kind (1=frame_err)", int'(o_frame_err), int'(mon_e.is_err));
                    lat = cyc - mon_e.t0;
                    compared++;
                    if (lat < LAT - 2 || lat > LAT + 2) begin
                        mismatched++;
                        $display("FAIL latency: got %0d cycles, expected %0d +/-2", lat, LAT);
                    end
                    if (!mon_e.is_err) begin
                        check("data byte", int'(o_data_byte), int'(mon_e.data));
                        model_byte = mon_e.data;
                    end else begin
                        check("byte held on frame error", int'(o_data_byte), int'(model_byte));
                    end
                end
            end else begin
                check("byte stable between pulses", int'(o_data_byte), int'(model_byte));
            end
        end
    end

    initial begin
        int         act_cnt;
        logic [7:0] rb;
        logic       rs;

        // Reset state
        idle(3);
        check("reset data_valid", int'(o_data_valid), 0);
        check("reset frame_err", int'(o_frame_err), 0);
        check("reset active", int'(o_active), 0);
        check("reset data_byte", int'(o_data_byte), 0);
        #2 rst_n = 1'b1;
        idle(4);

        // Single byte
        send_frame(8'hA5, 1'b1, 1'b1);
        idle(2 * CPB);
        check("active low after A5", int'(o_active), 0);
        check("A5 consumed", exp_q.size(), 0);

        // Back-to-back frames, no idle gap
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        send_frame(8'h5A, 1'b1, 1'b1);
        idle(2 * CPB);
        check("back-to-back consumed", exp_q.size(), 0);

        // Short start glitch
        @(negedge clk);
        i_rx    = 1'b0;
        act_cnt = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (k == 3) i_rx = 1'b1;
            if (o_active) act_cnt++;
        end
        check("glitch active window 1..8", int'(act_cnt >= 1 && act_cnt <= 8), 1);
        check("active low after glitch", int'(o_active), 0);

        // Stop bit low, line held in break
        send_frame(8'h3C, 1'b0, 1'b1);
        idle(100);
        check("active held during break", int'(o_active), 1);
        i_rx = 1'b1;
        idle(4);
        check("active low after break", int'(o_active), 0);
        idle(2);
        send_frame(8'h81, 1'b1, 1'b1);
        idle(2 * CPB);
        check("frame error sequence consumed", exp_q.size(), 0);

        // Reset during data bit 4 of 0xF0, released during bit 5
        fork
            send_frame(8'hF0, 1'b1, 1'b0);
            begin
                repeat (1 + 4 * CPB + CPB / 2) @(negedge clk);
                #2 rst_n = 1'b0;
                #1;
                check("mid-frame reset data_byte", int'(o_data_byte), 0);
                check("mid-frame reset active", int'(o_active), 0);
                check("mid-frame reset data_valid", int'(o_data_valid), 0);
                check("mid-frame reset frame_err", int'(o_frame_err), 0);
                model_byte = 8'h00;
                repeat (CPB) @(negedge clk);
                #2 rst_n = 1'b1;
            end
        join
        idle(2 * CPB);
        check("active low after aborted frame", int'(o_active), 0);
        send_frame(8'h12, 1'b1, 1'b1);
        idle(2 * CPB);

        // Random traffic: random bytes, gaps and occasional bad stop bits
        for (int n = 0; n < 30; n++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 4) != 0);
            send_frame(rb, rs, 1'b1);
            if (!rs) begin
                idle($urandom_range(0, 30));
                i_rx = 1'b1;
                idle(2);
            end
            idle($urandom_range(0, 20));
        end

        for (int w = 0; w < 3000 && (exp_q.size() != 0 || o_active); w++) @(negedge clk);
        check("scoreboard drained", exp_q.size(), 0);
        check("final active", int'(o_active), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10417, clk cycles per serial bit; legal range 4..65535.
REQ-002 SHALL have port clk  input  1  rising-edge system clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_rx  input  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-005 SHALL have port o_data_valid  output  1  one-cycle pulse: o_data_byte holds a new, correctly framed byte.
REQ-006 SHALL have port o_data_byte  output  8  last correctly received byte; stable between valid pulses.
REQ-007 SHALL have port o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-008 SHALL have port o_active  output  1  high while a frame is being received.

Function
REQ-009 SHALL pass i_rx through a 2-flop synchronizer (flops reset to 1); all decisions use the synchronized value rx_s.
REQ-010 SHALL implement FSM states IDLE, START, DATA, STOP, BREAK.
REQ-011 IDLE: counter=0, index=0; rx_s==0 -> START, o_active<=1.
REQ-012 START: count to (CLKS_PER_BIT-1)/2 (integer division); at that count, rx_s==0 -> DATA with counter=0; rx_s==1 -> glitch, return to IDLE, o_active<=0, no output pulse.
REQ-013 DATA: at counter==CLKS_PER_BIT-1, sample rx_s into shift bit[index], counter=0; index 0..7 increments; after index 7 sample -> STOP, index=0.
REQ-014 STOP: at counter==CLKS_PER_BIT-1, sample rx_s: 1 -> o_data_byte<=shift register, o_data_valid<=1 for one cycle, -> IDLE; 0 -> o_frame_err<=1 for one cycle, o_data_byte unchanged, -> BREAK.
REQ-015 BREAK: remain while rx_s==0 (line break/stuck low); rx_s==1 -> IDLE. o_active stays high in BREAK.
REQ-016 o_active SHALL drop in the same cycle as the transition to IDLE.
REQ-017 o_data_valid and o_frame_err SHALL never assert in the same cycle; each is high for exactly one clk.
REQ-018 Counter SHALL be 16 bits, never exceed CLKS_PER_BIT-1, and reset to 0 on every state change.
REQ-019 A new start bit SHALL be accepted in the cycle immediately after returning to IDLE (back-to-back frames with one stop bit).
REQ-020 Latency: valid pulse SHALL occur 2 (sync) + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + small constant cycles after the i_rx falling edge; bench checks window +/-2 cycles.

Reset
REQ-021 rst_n low SHALL immediately force: state=IDLE, counter=0, index=0, shift=0x00, o_data_byte=0x00, o_data_valid=0, o_frame_err=0, o_active=0, sync flops=1.
REQ-022 Reset mid-frame SHALL discard the partial byte; no pulse after release; next falling edge starts a fresh frame.

Structure
REQ-023 State encodings and default CLKS_PER_BIT SHALL live in a shared uart package used by both serial TX and uart_rx.
REQ-024 The synchronizer SHALL be a separate sub-module sync_2ff (reset value parameterized, default 1).

Verification (CLKS_PER_BIT=16, TX block looped back to i_rx unless stated)
REQ-025 Send 0xA5 -> exactly one o_data_valid pulse, o_data_byte=0xA5, o_frame_err never high, o_active low afterwards.
REQ-026 Back-to-back 0x00, 0xFF, 0x5A with no idle gap -> three valid pulses, bytes in order, no frame errors.
REQ-027 Drive i_rx low for 4 cycles then high -> no pulses, FSM returns to IDLE, o_active high <=8 cycles total.
REQ-028 Hand-driven frame 0x3C with stop bit low, line held low 100 cycles then high -> one o_frame_err pulse, no valid, o_data_byte keeps previous value, o_active high until line high; next 0x81 received correctly.
REQ-029 Assert rst_n low during data bit 4 of 0xF0, release mid-frame -> all outputs at reset values, no pulse for remainder; following 0x12 received correctly.
